// File: rtl/comparator_pkg.sv
// rtl/comparator_pkg.sv - shared state encoding and sizing helper for comparator_seq
package comparator_pkg;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/comparator_chunk.sv
// rtl/comparator_chunk.sv - combinational unsigned magnitude compare of one chunk
module comparator_chunk #(
  parameter int CHUNK = 3
) (
  input  logic [CHUNK-1:0] a_chunk,
  input  logic [CHUNK-1:0] b_chunk,
  output logic             chunk_lt,
  output logic             chunk_eq,
  output logic             chunk_gt
);

  assign chunk_lt = (a_chunk <  b_chunk);
  assign chunk_eq = (a_chunk == b_chunk);
  assign chunk_gt = (a_chunk >  b_chunk);

endmodule

// File: rtl/comparator_seq.sv
// rtl/comparator_seq.sv - multi-cycle magnitude comparator, one chunk per clock, MSB chunk first
module comparator_seq
  import comparator_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CHUNK      = 3,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  input  logic             l,
  input  logic             e,
  input  logic             g,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int NCHUNK = ceil_div(WIDTH, CHUNK);
  localparam int PW     = NCHUNK * CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] TOP_IDX = IW'(NCHUNK - 1);

  logic [0:0]    r_state;
  logic [PW-1:0] r_a;
  logic [PW-1:0] r_b;
  logic [2:0]    r_leg;
  logic [IW-1:0] r_idx;
  logic          r_dec_vld;
  logic          r_dec_lt;
  logic          r_dec_gt;
  logic          r_done;
  logic          r_lt;
  logic          r_eq;
  logic          r_gt;

  logic [WIDTH-1:0] w_a_in;
  logic [WIDTH-1:0] w_b_in;
  logic [PW-1:0]    w_a_sh;
  logic [PW-1:0]    w_b_sh;
  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic             w_chunk_lt;
  logic             w_chunk_eq;
  logic             w_chunk_gt;
  logic             w_diff;
  logic             w_finish;
  logic [2:0]       w_result;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign w_a_in = signed_mode ? {~a[WIDTH-1], a[WIDTH-2:0]} : a;
  assign w_b_in = signed_mode ? {~b[WIDTH-1], b[WIDTH-2:0]} : b;

  assign w_a_sh    = r_a >> (int'(r_idx) * CHUNK);
  assign w_b_sh    = r_b >> (int'(r_idx) * CHUNK);
  assign w_a_chunk = w_a_sh[CHUNK-1:0];
  assign w_b_chunk = w_b_sh[CHUNK-1:0];

  comparator_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a_chunk  (w_a_chunk),
    .b_chunk  (w_b_chunk),
    .chunk_lt (w_chunk_lt),
    .chunk_eq (w_chunk_eq),
    .chunk_gt (w_chunk_gt)
  );

  assign w_diff   = ~w_chunk_eq;
  assign w_finish = (r_idx == '0) || ((EARLY_EXIT != 0) && w_diff);

  // An earlier latched decision always outranks the current chunk.
  always_comb begin
    w_result = r_leg;
    if (r_dec_vld) begin
      w_result = {r_dec_lt, 1'b0, r_dec_gt};
    end else if (w_diff) begin
      w_result = {w_chunk_lt, 1'b0, w_chunk_gt};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_leg     <= '0;
      r_idx     <= '0;
      r_dec_vld <= 1'b0;
      r_dec_lt  <= 1'b0;
      r_dec_gt  <= 1'b0;
      r_done    <= 1'b0;
      r_lt      <= 1'b0;
      r_eq      <= 1'b0;
      r_gt      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (start) begin
          r_a       <= PW'(w_a_in);
          r_b       <= PW'(w_b_in);
          r_leg     <= {l, e, g};
          r_idx     <= TOP_IDX;
          r_dec_vld <= 1'b0;
          r_dec_lt  <= 1'b0;
          r_dec_gt  <= 1'b0;
          r_state   <= RUN;
        end
      end else begin
        if (w_finish) begin
          r_state <= IDLE;
          r_done  <= 1'b1;
          r_lt    <= w_result[2];
          r_eq    <= w_result[1];
          r_gt    <= w_result[0];
        end else begin
          r_idx <= r_idx - IW'(1);
          if (!r_dec_vld && w_diff) begin
            r_dec_vld <= 1'b1;
            r_dec_lt  <= w_chunk_lt;
            r_dec_gt  <= w_chunk_gt;
          end
        end
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = r_done;
  assign lt   = r_lt;
  assign eq   = r_eq;
  assign gt   = r_gt;

endmodule

// File: tb/tb_comparator_seq.sv
// tb/tb_comparator_seq.sv - self-checking bench for comparator_seq, early-exit and full-scan instances
module tb_comparator_seq;

  localparam int WIDTH  = 8;
  localparam int CHUNK  = 3;
  localparam int NCHUNK = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             signed_mode = 1'b0;
  logic             l = 1'b0;
  logic             e = 1'b0;
  logic             g = 1'b0;

  logic busy1, done1, lt1, eq1, gt1;
  logic busy0, done0, lt0, eq0, gt0;

  int npass  = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  comparator_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK), .EARLY_EXIT(1)) u_dut_ee1 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .signed_mode(signed_mode), .l(l), .e(e), .g(g),
    .busy(busy1), .done(done1), .lt(lt1), .eq(eq1), .gt(gt1)
  );

  comparator_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK), .EARLY_EXIT(0)) u_dut_ee0 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .signed_mode(signed_mode), .l(l), .e(e), .g(g),
    .busy(busy0), .done(done0), .lt(lt0), .eq(eq0), .gt(gt0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal = ntotal + 1;
    assert (obs === exp) npass = npass + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Result as {lt,eq,gt}: plain integer compare, cascade inputs only on equality.
  function automatic logic [2:0] ref_res(input logic [7:0] x, input logic [7:0] y,
                                         input bit sm, input logic [2:0] leg);
    if (x == y) return leg;
    if (sm) return ($signed(x) < $signed(y)) ? 3'b100 : 3'b001;
    return (x < y) ? 3'b100 : 3'b001;
  endfunction

  // Cycles to done: early exit stops at the chunk holding the highest differing bit.
  function automatic int ref_lat(input logic [7:0] x, input logic [7:0] y, input bit ee);
    logic [7:0] d;
    int p;
    d = x ^ y;
    p = -1;
    if (!ee) return NCHUNK;
    for (int i = 0; i < WIDTH; i++) if (d[i]) p = i;
    if (p < 0) return NCHUNK;
    return NCHUNK - p / CHUNK;
  endfunction

  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic ism,
                        input logic [2:0] ileg, input string tag);
    int lat1, lat0, n1, n0;
    logic [2:0] r1, r0, exp_r;
    a = ia; b = ib; signed_mode = ism; {l, e, g} = ileg; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_ee1"}, busy1, 1);
    check({tag, "_busy_ee0"}, busy0, 1);
    lat1 = 0; lat0 = 0; n1 = 0; n0 = 0; r1 = 3'b000; r0 = 3'b000;
    for (int c = 1; c <= NCHUNK + 2; c++) begin
      @(posedge clk); #1;
      if (done1) begin n1++; lat1 = c; r1 = {lt1, eq1, gt1}; end
      if (done0) begin n0++; lat0 = c; r0 = {lt0, eq0, gt0}; end
    end
    exp_r = ref_res(ia, ib, ism, ileg);
    check({tag, "_res_ee1"}, r1, exp_r);
    check({tag, "_res_ee0"}, r0, exp_r);
    check({tag, "_lat_ee1"}, lat1, ref_lat(ia, ib, 1'b1));
    check({tag, "_lat_ee0"}, lat0, ref_lat(ia, ib, 1'b0));
    check({tag, "_ndone_ee1"}, n1, 1);
    check({tag, "_ndone_ee0"}, n0, 1);
    check({tag, "_idle_ee1"}, busy1, 0);
  endtask

  initial begin
    int ndone;
    logic [7:0] ra, rb;

    #2;
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_res", {lt1, eq1, gt1}, 3'b000);
    check("rst_res_ee0", {busy0, done0, lt0, eq0, gt0}, 5'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op(8'h80, 8'h7F, 1'b0, 3'b010, "top_unsigned");
    run_op(8'h80, 8'h7F, 1'b1, 3'b010, "top_signed");
    run_op(8'h5A, 8'h5A, 1'b0, 3'b100, "eq_pass");
    run_op(8'h05, 8'h04, 1'b0, 3'b010, "low_chunk");
    run_op(8'h33, 8'h33, 1'b1, 3'b101, "eq_nonhot");
    run_op(8'h7F, 8'hFF, 1'b1, 3'b000, "signed_neg");

    // Start re-pulsed during RUN is ignored; start on the done cycle is taken.
    a = 8'h5A; b = 8'h5A; signed_mode = 1'b0; {l, e, g} = 3'b100; start = 1'b1;
    @(posedge clk); #1;
    a = 8'hFF; b = 8'h00; {l, e, g} = 3'b001;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("b2b_nodone_early", done1, 0);
    @(posedge clk); #1;
    check("b2b_done1", done1, 1);
    check("b2b_res1", {lt1, eq1, gt1}, 3'b100);
    check("b2b_res1_ee0", {done0, lt0, eq0, gt0}, 4'b1100);
    a = 8'h05; b = 8'h04; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_accept", busy1, 1);
    check("b2b_done_low", done1, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("b2b_nodone2", done1, 0);
    @(posedge clk); #1;
    check("b2b_done2", done1, 1);
    check("b2b_res2", {lt1, eq1, gt1}, 3'b001);

    // Reset in the second RUN cycle aborts with results cleared.
    a = 8'h5A; b = 8'h5A; {l, e, g} = 3'b010; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", busy1, 0);
    check("rst_mid_res", {lt1, eq1, gt1}, 3'b000);
    check("rst_mid_ee0", {busy0, lt0, eq0, gt0}, 4'b0000);
    ndone = 0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      if (done1 || done0) ndone++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (done1 || done0) ndone++;
    end
    check("rst_mid_nodone", ndone, 0);

    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    run_op(8'hC3, 8'h3C, 1'b1, 3'b010, "post_rst");

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
      run_op(ra, rb, 1'($urandom), 3'($urandom), $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
